sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle bridge between the MEM stage's 32-bit data-memory requests and an external 16-bit asynchronous SRAM. Each 32-bit access is split into a low-half and a high-half SRAM access, each held for a programmable number of wait cycles. `ready` is the pipeline's freeze source: while it is low, the core holds all stage registers and keeps the request stable.

## Interface
- `WAIT_CYCLES`, default 2: cycles each half-word SRAM access is held; legal range ≥1.
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write request from the MEM stage.
- `rd_en`  in  1: read request from the MEM stage.
- `address`  in  32: byte address of the access.
- `write_data`  in  32: store data.
- `read_data`  out  32: load data, registered.
- `ready`  out  1: high when no access is pending or the current access completes this cycle.
- `sram_addr`  out  18: SRAM half-word address.
- `sram_dq`  inout  16: SRAM data bus.
- `sram_we_n`  out  1: SRAM write enable, active low.

## Operation
- Word index: `word = (address - DATA_BASE) >> 2`.
  - Subtraction is modulo 2^32 and unchecked.
  - Addresses below `DATA_BASE` wrap silently; no error signal.
- Low-half SRAM address is `{word[16:0],1'b0}`; high-half address is `{word[16:0],1'b1}`.
- Request priority: if `wr_en` and `rd_en` are both high, the access is a write.
- FSM states: IDLE, LOW, HIGH, DONE. A wait counter is sized `$clog2(WAIT_CYCLES+1)`.
  - **IDLE**: on `wr_en|rd_en`, latch the access type and go to LOW with the counter cleared. Otherwise stay.
  - **LOW**: drive the low-half address.
    - On a write: drive `write_data[15:0]` on `sram_dq` and hold `sram_we_n=0`.
    - Stay for `WAIT_CYCLES` cycles.
    - On the last cycle of a read, capture `sram_dq` into `read_data[15:0]`.
    - Then go to HIGH with the counter cleared.
  - **HIGH**: same as LOW, but uses the high-half address and `write_data[31:16]`.
    - On the last cycle of a read, capture `sram_dq` into `read_data[31:16]`.
    - Then go to DONE.
  - **DONE**: `ready=1` for exactly one cycle, then return to IDLE unconditionally.
    - A request still present in IDLE on the following cycle is treated as a new access.
- `ready` is combinational:
  - In IDLE: `~(wr_en|rd_en)`.
  - In LOW and HIGH: 0.
  - In DONE: 1.
- Outside write phases:
  - `sram_dq` is high-Z.
  - `sram_we_n` is 1.
  - `sram_addr` is 0 in IDLE and DONE.
- `read_data` holds its last value until the next read overwrites it. Writes never modify it.
- The access type is sampled once, in IDLE. The requester must hold `address` and `write_data` stable until `ready`. Changing them mid-access is undefined.

## Timing
- Request first seen high at cycle 0 (IDLE, `ready=0`):
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready=1` and `read_data` valid.
- With the default W=2, `ready` rises in cycle 5, giving a stall of 5 cycles.
- Reset values: FSM in IDLE, counter 0, `read_data=0`, `sram_we_n=1`, `sram_addr=0`, `sram_dq` high-Z. `ready` follows the request inputs immediately.
- Reset mid-access aborts the access with no further SRAM writes.
  - A half already written stays in the SRAM.
  - A partially captured `read_data` is cleared to 0.
- `sram_we_n` deasserts in the same edge that leaves a write phase. Address and data stay valid through that edge, giving zero hold time relative to the controller clock.

## Test plan
- **Write:** W=2, `wr_en=1`, address 1024, data 0xDEADBEEF.
  - SRAM addr 0 receives 0xBEEF in cycles 1-2.
  - SRAM addr 1 receives 0xDEAD in cycles 3-4.
  - `ready=1` only in cycle 5.
- **Read:** `rd_en=1`, address 1024, with an SRAM model holding 0xBEEF/0xDEAD.
  - `read_data=0xDEADBEEF` in cycle 5.
  - `sram_we_n` stays 1 and `sram_dq` is never driven by the controller.
- **Address mapping:** address 1032 → SRAM addresses 4 and 5. Address 1020 → wraps, giving SRAM addresses 0x3FFFE and 0x3FFFF.
- **Back-to-back and priority:**
  - Request held across DONE → a second full access starts in the following IDLE cycle, with `ready` low again.
  - `wr_en` and `rd_en` both high → a write is performed.
- **Reset mid-access:** `rst` asserted in cycle 3 of a write.
  - Immediate IDLE, `sram_we_n=1`, `sram_dq` high-Z.
  - SRAM addr 1 keeps its prior value.
  - `read_data=0`.
- **Minimum wait:** W=1, read → `ready` in cycle 3. With no request, `ready` stays 1 and the FSM stays in IDLE.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller
// Bridges 32-bit data-memory requests from the MEM stage onto a 16-bit
// asynchronous SRAM. Each word access is split into a low half-word access
// and a high half-word access. Each half is held for WAIT_CYCLES clocks.
//
// Parameters
//   WAIT_CYCLES : clocks each half-word access is held (>= 1)
//   DATA_BASE   : byte address mapped to SRAM word 0
// Ports
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   wr_en/rd_en : MEM-stage request (write wins when both are high)
//   address     : byte address, held stable by the requester until ready
//   write_data  : store data, held stable until ready
//   read_data   : registered load data
//   ready       : pipeline freeze release (combinational)
//   sram_addr   : SRAM half-word address
//   sram_dq     : SRAM bidirectional data bus
//   sram_we_n   : SRAM write enable, active low
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] DATA_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             is_wr_r, is_wr_nxt_s;
    logic             last_s;

    logic [31:0]      offset_s;
    logic [14:0]      unused_offset_s;
    logic [17:0]      lo_addr_s, hi_addr_s;

    logic [31:0]      read_data_r;
    logic [17:0]      sram_addr_r, sram_addr_nxt_s;
    logic             we_n_r, we_n_nxt_s;
    logic [15:0]      dq_out_r, dq_out_nxt_s;
    logic             dq_oe_r;
    logic             ready_s;

    // Address mapping: wraps modulo 2^32; only word bits [16:0] reach the SRAM.
    assign offset_s        = address - DATA_BASE;
    assign unused_offset_s = {offset_s[31:19], offset_s[1:0]};
    assign lo_addr_s       = {offset_s[18:2], 1'b0};
    assign hi_addr_s       = {offset_s[18:2], 1'b1};

    assign last_s = (cnt_r == CNT_LAST);

    // Next-state, wait-counter and access-type logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        is_wr_nxt_s = is_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_en || rd_en) begin
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                    is_wr_nxt_s = wr_en;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (last_s) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // SRAM pin values for the upcoming state, so the pins come straight
    // from flops and we_n drops on the same edge that leaves a write phase.
    always_comb begin
        sram_addr_nxt_s = 18'd0;
        dq_out_nxt_s    = write_data[15:0];
        case (state_nxt_s)
            ST_LOW: begin
                sram_addr_nxt_s = lo_addr_s;
                dq_out_nxt_s    = write_data[15:0];
            end
            ST_HIGH: begin
                sram_addr_nxt_s = hi_addr_s;
                dq_out_nxt_s    = write_data[31:16];
            end
            default: begin
                sram_addr_nxt_s = 18'd0;
            end
        endcase
        we_n_nxt_s = ~(is_wr_nxt_s &&
                       ((state_nxt_s == ST_LOW) || (state_nxt_s == ST_HIGH)));
    end

    // Ready: follows the request in IDLE, low during a phase, high in DONE.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = ~(wr_en | rd_en);
            ST_LOW:  ready_s = 1'b0;
            ST_HIGH: ready_s = 1'b0;
            ST_DONE: ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // FSM, wait counter and latched access type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            is_wr_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            is_wr_r <= is_wr_nxt_s;
        end
    end

    // Registered SRAM pins; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr_r <= 18'd0;
            we_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            sram_addr_r <= sram_addr_nxt_s;
            we_n_r      <= we_n_nxt_s;
            dq_oe_r     <= ~we_n_nxt_s;
            dq_out_r    <= dq_out_nxt_s;
        end
    end

    // Read capture on the last wait cycle of each half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_r <= 32'd0;
        end else if (!is_wr_r && last_s && (state_r == ST_LOW)) begin
            read_data_r[15:0] <= sram_dq;
        end else if (!is_wr_r && last_s && (state_r == ST_HIGH)) begin
            read_data_r[31:16] <= sram_dq;
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign sram_dq   = dq_oe_r ? dq_out_r : 16'hzzzz;
    assign sram_addr = sram_addr_r;
    assign sram_we_n = we_n_r;
    assign read_data = read_data_r;
    assign ready     = ready_s;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Directed bench for sram_controller. dut0 (W=2) talks to a full-size
// half-word SRAM model. dut1 (W=1) talks to a fixed-pattern responder.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;

    logic        wr1, rd1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1;
    logic        ready1;
    logic [17:0] saddr1;
    wire  [15:0] dq1;
    logic        we1_n;

    logic [15:0] mem [0:262143];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(2), .DATA_BASE(32'd1024)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1), .DATA_BASE(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
        .address(addr1), .write_data(wdata1), .read_data(rdata1),
        .ready(ready1), .sram_addr(saddr1), .sram_dq(dq1),
        .sram_we_n(we1_n)
    );

    // Asynchronous SRAM with output enable tied active: it drives the bus
    // whenever it is not being written.
    assign sram_dq = sram_we_n ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq;
    end

    assign dq1 = we1_n ? (saddr1[0] ? 16'h5678 : 16'h1234) : 16'hzzzz;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=2 access from cycle 0 to DONE (cycle 5); exp_rd is the value
    // read_data must hold at DONE (the previous value for writes).
    task automatic run_access(input string tag, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [17:0] base, input logic [31:0] exp_rd,
                              input logic hold);
        logic lo;
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        check_eq({tag, " c0 ready"}, {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            lo = (c <= 2);
            check_eq($sformatf("%s c%0d ready", tag, c), {31'd0, ready}, 32'd0);
            check_eq($sformatf("%s c%0d addr", tag, c), {14'd0, sram_addr},
                     {14'd0, lo ? base : base + 18'd1});
            check_eq($sformatf("%s c%0d we_n", tag, c), {31'd0, sram_we_n},
                     {31'd0, ~w});
            if (w) begin
                check_eq($sformatf("%s c%0d dq", tag, c), {16'd0, sram_dq},
                         {16'd0, lo ? d[15:0] : d[31:16]});
            end
        end
        tick();
        check_eq({tag, " c5 ready"}, {31'd0, ready}, 32'd1);
        check_eq({tag, " c5 we_n"}, {31'd0, sram_we_n}, 32'd1);
        check_eq({tag, " c5 addr"}, {14'd0, sram_addr}, 32'd0);
        check_eq({tag, " c5 rdata"}, read_data, exp_rd);
        if (!hold) begin
            wr_en = 1'b0; rd_en = 1'b0;
            tick();
            check_eq({tag, " idle ready"}, {31'd0, ready}, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'd1024; wdata1 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst rdata", read_data, 32'd0);
        check_eq("rst we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("rst addr", {14'd0, sram_addr}, 32'd0);
        check_eq("rst ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        tick();

        run_access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0, 1'b0);
        check_eq("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        check_eq("mem1", {16'd0, mem[1]}, 32'h0000DEAD);

        run_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF, 1'b0);

        run_access("wr1032", 1'b1, 1'b0, 32'd1032, 32'h11112222, 18'd4, 32'hDEADBEEF, 1'b0);
        check_eq("mem4", {16'd0, mem[4]}, 32'h00002222);
        check_eq("mem5", {16'd0, mem[5]}, 32'h00001111);
        run_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'd0, 18'd4, 32'h11112222, 1'b0);

        run_access("wr1020", 1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 32'h11112222, 1'b0);
        check_eq("mem3FFFE", {16'd0, mem[18'h3FFFE]}, 32'h00005A5A);
        check_eq("mem3FFFF", {16'd0, mem[18'h3FFFF]}, 32'h0000A5A5);

        run_access("prio", 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 18'd8, 32'h11112222, 1'b0);
        check_eq("mem8", {16'd0, mem[8]}, 32'h0000F00D);
        check_eq("mem9", {16'd0, mem[9]}, 32'h0000CAFE);

        // Request held across DONE starts a second access.
        run_access("b2b_a", 1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF, 1'b1);
        tick();
        check_eq("b2b idle ready", {31'd0, ready}, 32'd0);
        run_access("b2b_b", 1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF, 1'b0);

        // Reset in cycle 3 of a write: high half must not reach the SRAM.
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h12345678;
        repeat (3) tick();
        check_eq("rstmid pre we_n", {31'd0, sram_we_n}, 32'd0);
        check_eq("rstmid pre addr", {14'd0, sram_addr}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstmid we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("rstmid addr", {14'd0, sram_addr}, 32'd0);
        check_eq("rstmid rdata", read_data, 32'd0);
        check_eq("rstmid ready req", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        #1;
        check_eq("rstmid ready idle", {31'd0, ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check_eq("rstmid mem0", {16'd0, mem[0]}, 32'h00005678);
        check_eq("rstmid mem1", {16'd0, mem[1]}, 32'h0000DEAD);

        // W=1: idle stays ready, then a read completes in cycle 3.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("w1 idle%0d ready", i), {31'd0, ready1}, 32'd1);
            check_eq($sformatf("w1 idle%0d addr", i), {14'd0, saddr1}, 32'd0);
        end
        rd1 = 1'b1;
        #1;
        check_eq("w1 c0 ready", {31'd0, ready1}, 32'd0);
        tick();
        check_eq("w1 c1 ready", {31'd0, ready1}, 32'd0);
        check_eq("w1 c1 addr", {14'd0, saddr1}, 32'd0);
        check_eq("w1 c1 we_n", {31'd0, we1_n}, 32'd1);
        tick();
        check_eq("w1 c2 ready", {31'd0, ready1}, 32'd0);
        check_eq("w1 c2 addr", {14'd0, saddr1}, 32'd1);
        tick();
        check_eq("w1 c3 ready", {31'd0, ready1}, 32'd1);
        check_eq("w1 c3 rdata", rdata1, 32'h56781234);
        rd1 = 1'b0;
        tick();
        check_eq("w1 after ready", {31'd0, ready1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
